// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Packet-granular round-robin arbiter sharing one uart_tx
//               serializer between NUM_REQ byte-stream requesters.
//               Optional idle-owner timeout enabled by defining ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int TIMEOUT_CLKS = 1024
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic [NUM_REQ-1:0]   i_Req,
    input  logic [8*NUM_REQ-1:0] i_Req_Byte,
    input  logic [NUM_REQ-1:0]   i_Req_Last,
    output logic [NUM_REQ-1:0]   o_Req_Ack,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done,
    output logic                 o_Busy
`ifdef ARB_TIMEOUT_EN
   ,output logic                 o_Timeout
`endif
);

    localparam int IDXW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        s_IDLE      = 3'd0,
        s_LOAD      = 3'd1,
        s_SEND      = 3'd2,
        s_WAIT_DONE = 3'd3,
        s_NEXT      = 3'd4
    } state_t;

    state_t               r_State;
    logic [IDXW-1:0]      r_Ptr;
    logic [IDXW-1:0]      r_Owner;
    logic                 r_Last;
    logic                 r_Done_Dly;
    logic                 r_Rst_Wait;
    logic [NUM_REQ-1:0]   r_Grant;
    logic [NUM_REQ-1:0]   r_Ack;
    logic                 r_Tx_DV;
    logic [7:0]           r_Tx_Byte;
    logic                 r_Busy;

    logic                 w_Win_Found;
    logic [IDXW-1:0]      w_Win_Idx;
    logic [IDXW-1:0]      w_Next_Ptr;
    logic                 w_Done_Rise;
    int                   w_Cand;

    // Scan downward so the nearest requester at or after the pointer wins.
    always_comb begin
        w_Win_Found = 1'b0;
        w_Win_Idx   = '0;
        w_Cand      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (int'(r_Ptr) + k >= NUM_REQ) w_Cand = int'(r_Ptr) + k - NUM_REQ;
            else                            w_Cand = int'(r_Ptr) + k;
            if (i_Req[w_Cand[IDXW-1:0]]) begin
                w_Win_Found = 1'b1;
                w_Win_Idx   = w_Cand[IDXW-1:0];
            end
        end
    end

    assign w_Next_Ptr  = (r_Owner == IDXW'(NUM_REQ - 1)) ? '0 : r_Owner + 1'b1;
    assign w_Done_Rise = i_Tx_Done & ~r_Done_Dly;

`ifdef ARB_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CLKS);
    logic [TOW-1:0] r_To_Cnt;
    logic           r_Timeout;
    assign o_Timeout = r_Timeout;
`endif

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State    <= s_IDLE;
            r_Ptr      <= '0;
            r_Owner    <= '0;
            r_Last     <= 1'b0;
            r_Done_Dly <= 1'b0;
            r_Rst_Wait <= 1'b1;
            r_Grant    <= '0;
            r_Ack      <= '0;
            r_Tx_DV    <= 1'b0;
            r_Tx_Byte  <= '0;
            r_Busy     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_To_Cnt   <= '0;
            r_Timeout  <= 1'b0;
`endif
        end else begin
            r_Ack      <= '0;
            r_Done_Dly <= i_Tx_Done;
            // A byte started before reset may still be on the wire.
            if (!i_Tx_Active) r_Rst_Wait <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_Timeout  <= 1'b0;
`endif
            case (r_State)
                s_IDLE: begin
                    if (w_Win_Found) begin
                        r_Owner <= w_Win_Idx;
                        r_Grant <= NUM_REQ'(1) << w_Win_Idx;
                        r_Busy  <= 1'b1;
                        r_State <= s_LOAD;
                    end
                end
                s_LOAD: begin
                    r_Tx_Byte      <= i_Req_Byte[{r_Owner, 3'b000} +: 8];
                    r_Last         <= i_Req_Last[r_Owner];
                    r_Ack[r_Owner] <= 1'b1;
                    r_State        <= s_SEND;
                end
                s_SEND: begin
                    // DV is held until the serializer reports active.
                    if (!r_Tx_DV) begin
                        if (!r_Rst_Wait) r_Tx_DV <= 1'b1;
                    end else if (i_Tx_Active) begin
                        r_Tx_DV <= 1'b0;
                        r_State <= s_WAIT_DONE;
                    end
                end
                s_WAIT_DONE: begin
                    if (w_Done_Rise) r_State <= s_NEXT;
                end
                s_NEXT: begin
                    if (r_Last) begin
                        r_Grant <= '0;
                        r_Busy  <= 1'b0;
                        r_Ptr   <= w_Next_Ptr;
                        r_State <= s_IDLE;
`ifdef ARB_TIMEOUT_EN
                        r_To_Cnt <= '0;
`endif
                    end else if (i_Req[r_Owner]) begin
                        r_State <= s_LOAD;
`ifdef ARB_TIMEOUT_EN
                        r_To_Cnt <= '0;
`endif
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (r_To_Cnt == TOW'(TIMEOUT_CLKS - 1)) begin
                        r_Grant   <= '0;
                        r_Busy    <= 1'b0;
                        r_Ptr     <= w_Next_Ptr;
                        r_State   <= s_IDLE;
                        r_Timeout <= 1'b1;
                        r_To_Cnt  <= '0;
                    end else begin
                        r_To_Cnt <= r_To_Cnt + 1'b1;
                    end
`endif
                end
                default: r_State <= s_IDLE;
            endcase
        end
    end

    assign o_Req_Ack = r_Ack;
    assign o_Grant   = r_Grant;
    assign o_Tx_DV   = r_Tx_DV;
    assign o_Tx_Byte = r_Tx_Byte;
    assign o_Busy    = r_Busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter driving a
//               behavioural uart_tx model (CLKS_PER_BIT = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int CPB = 8;
    localparam int M_IDLE = 0, M_START = 1, M_DATA = 2, M_STOP = 3, M_CLEAN = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_byte;
    logic [N-1:0]   req_last;
    logic [N-1:0]   ack;
    logic [N-1:0]   grant;
    logic           tx_dv;
    logic [7:0]     tx_byte;
    logic           tx_active = 1'b0;
    logic           tx_done   = 1'b0;
    logic           busy;
`ifdef ARB_TIMEOUT_EN
    logic           timeout;
`endif

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CLKS(16)) dut (
        .i_Clock    (clk),
        .i_Rst_L    (rst_n),
        .i_Req      (req),
        .i_Req_Byte (req_byte),
        .i_Req_Last (req_last),
        .o_Req_Ack  (ack),
        .o_Grant    (grant),
        .o_Tx_DV    (tx_dv),
        .o_Tx_Byte  (tx_byte),
        .i_Tx_Active(tx_active),
        .i_Tx_Done  (tx_done),
        .o_Busy     (busy)
`ifdef ARB_TIMEOUT_EN
       ,.o_Timeout  (timeout)
`endif
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [8:0]  rq [N][$];
    int          ack_log[$];
    logic [7:0]  tx_log[$];
    logic [7:0]  rx_log[$];
    int          frame_err = 0;

    // Behavioural uart_tx: DV ignored outside idle, Done high for two cycles.
    int         m_state = M_IDLE, m_cnt = 0, m_bit = 0;
    logic [7:0] m_data = 8'h00;
    logic       m_serial = 1'b1;
    always @(posedge clk) begin
        case (m_state)
            M_IDLE: begin
                m_serial <= 1'b1; tx_done <= 1'b0; m_cnt <= 0; m_bit <= 0;
                if (tx_dv) begin
                    tx_active <= 1'b1; m_data <= tx_byte; tx_log.push_back(tx_byte);
                    m_state <= M_START;
                end
            end
            M_START: begin
                m_serial <= 1'b0;
                if (m_cnt < CPB - 1) m_cnt <= m_cnt + 1;
                else begin m_cnt <= 0; m_state <= M_DATA; end
            end
            M_DATA: begin
                m_serial <= m_data[m_bit];
                if (m_cnt < CPB - 1) m_cnt <= m_cnt + 1;
                else begin
                    m_cnt <= 0;
                    if (m_bit < 7) m_bit <= m_bit + 1;
                    else begin m_bit <= 0; m_state <= M_STOP; end
                end
            end
            M_STOP: begin
                m_serial <= 1'b1;
                if (m_cnt < CPB - 1) m_cnt <= m_cnt + 1;
                else begin
                    m_cnt <= 0; tx_done <= 1'b1; tx_active <= 1'b0; m_state <= M_CLEAN;
                end
            end
            default: begin tx_done <= 1'b1; m_state <= M_IDLE; end
        endcase
    end

    logic [7:0] rx_b;
    initial begin
        forever begin
            @(negedge m_serial);
            repeat (CPB / 2) @(posedge clk);
            if (m_serial !== 1'b0) frame_err++;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                rx_b[i] = m_serial;
            end
            repeat (CPB) @(posedge clk);
            if (m_serial !== 1'b1) frame_err++;
            rx_log.push_back(rx_b);
        end
    end

    task automatic drive();
        logic [8:0] e;
        for (int k = 0; k < N; k++) begin
            if (rq[k].size() > 0) begin
                e = rq[k][0];
                req[k] = 1'b1; req_byte[k*8 +: 8] = e[7:0]; req_last[k] = e[8];
            end else begin
                req[k] = 1'b0; req_byte[k*8 +: 8] = 8'h00; req_last[k] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            if (ack[k] === 1'b1) begin
                ack_log.push_back(k);
                if (rq[k].size() > 0) void'(rq[k].pop_front());
            end
        end
        drive();
    endtask

    function automatic bit all_empty();
        bit r = 1'b1;
        for (int k = 0; k < N; k++) if (rq[k].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (all_empty() && grant == '0 && !busy && m_state == M_IDLE && !tx_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [63:0] pack_acks();
        logic [63:0] r = '0;
        foreach (ack_log[i]) r = (r << 4) | 64'(ack_log[i] + 1);
        return r;
    endfunction

    function automatic logic [63:0] pack_tx();
        logic [63:0] r = '0;
        foreach (tx_log[i]) r = (r << 8) | 64'(tx_log[i]);
        return r;
    endfunction

    function automatic logic [63:0] pack_rx();
        logic [63:0] r = '0;
        foreach (rx_log[i]) r = (r << 8) | 64'(rx_log[i]);
        return r;
    endfunction

    task automatic clear_logs();
        ack_log.delete(); tx_log.delete(); rx_log.delete(); frame_err = 0;
    endtask

    task automatic do_reset();
        for (int k = 0; k < N; k++) rq[k].delete();
        rst_n = 1'b0; drive();
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; drive();
        step(); step();
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (tx_dv !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b expected 0", tx_dv); end
        n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", ack); end
        n_tests++; if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %h expected 00", tx_byte); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        bit ok;
        clear_logs();
        rq[0].push_back(9'h155); drive();
        step();
        n_tests++; if (grant !== 4'b0001 || busy !== 1'b1) begin n_fail++; $display("FAIL single_grant: got grant=%b busy=%b expected 0001/1", grant, busy); end
        step();
        n_tests++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b expected 0001", ack); end
        step();
        n_tests++; if (tx_dv !== 1'b1 || tx_byte !== 8'h55) begin n_fail++; $display("FAIL single_dv: got dv=%b byte=%h expected 1/55", tx_dv, tx_byte); end
        wait_idle(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL single_idle: got no return to idle expected idle"); end
        n_tests++; if (pack_tx() !== 64'h55) begin n_fail++; $display("FAIL single_tx: got %h expected 55", pack_tx()); end
        n_tests++; if (pack_rx() !== 64'h55 || frame_err != 0) begin n_fail++; $display("FAIL single_serial: got %h ferr=%0d expected 55 ferr=0", pack_rx(), frame_err); end
        n_tests++; if (pack_acks() !== 64'h1) begin n_fail++; $display("FAIL single_acks: got %h expected 1", pack_acks()); end
    endtask

    task automatic test_pointer();
        bit ok;
        clear_logs();
        rq[0].push_back(9'h1C0); rq[1].push_back(9'h1C1); drive();
        wait_idle(ok);
        n_tests++; if (!ok || pack_acks() !== 64'h21) begin n_fail++; $display("FAIL pointer_acks: got %h expected 21", pack_acks()); end
        n_tests++; if (pack_tx() !== 64'hC1C0) begin n_fail++; $display("FAIL pointer_tx: got %h expected c1c0", pack_tx()); end
    endtask

    task automatic test_round_robin();
        bit ok;
        clear_logs();
        for (int k = 0; k < N; k++) rq[k].push_back({1'b1, 8'(8'hA0 + k)});
        rq[0].push_back(9'h1B0); drive();
        wait_idle(ok);
        n_tests++; if (!ok || pack_acks() !== 64'h12341) begin n_fail++; $display("FAIL rr_acks: got %h expected 12341", pack_acks()); end
        n_tests++; if (pack_tx() !== 64'hA0A1A2A3B0) begin n_fail++; $display("FAIL rr_tx: got %h expected a0a1a2a3b0", pack_tx()); end
        n_tests++; if (pack_rx() !== 64'hA0A1A2A3B0) begin n_fail++; $display("FAIL rr_serial: got %h expected a0a1a2a3b0", pack_rx()); end
    endtask

    task automatic test_packet();
        bit ok;
        clear_logs();
        rq[2].push_back(9'h011); rq[2].push_back(9'h022); rq[2].push_back(9'h133);
        rq[0].push_back(9'h144); drive();
        wait_idle(ok);
        n_tests++; if (!ok || pack_acks() !== 64'h3331) begin n_fail++; $display("FAIL packet_acks: got %h expected 3331", pack_acks()); end
        n_tests++; if (pack_tx() !== 64'h11223344) begin n_fail++; $display("FAIL packet_tx: got %h expected 11223344", pack_tx()); end
    endtask

    task automatic test_back_to_back();
        bit ok = 1'b0;
        logic prev = 1'b0, prev2 = 1'b0;
        int rises = 0;
        clear_logs();
        rq[3].push_back(9'h0D1); rq[3].push_back(9'h0D2); rq[3].push_back(9'h1D3); drive();
        for (int i = 0; i < 3000; i++) begin
            step();
            if (tx_active && !prev) begin
                rises++;
                n_tests++; if (tx_dv !== 1'b1) begin n_fail++; $display("FAIL b2b_dv_hold: got %b expected 1", tx_dv); end
            end
            if (prev && !prev2) begin
                n_tests++; if (tx_dv !== 1'b0) begin n_fail++; $display("FAIL b2b_dv_release: got %b expected 0", tx_dv); end
            end
            prev2 = prev; prev = tx_active;
            if (all_empty() && grant == '0 && m_state == M_IDLE && !tx_done) begin ok = 1'b1; break; end
        end
        n_tests++; if (!ok || rises != 3) begin n_fail++; $display("FAIL b2b_count: got %0d bytes expected 3", rises); end
        n_tests++; if (pack_tx() !== 64'hD1D2D3) begin n_fail++; $display("FAIL b2b_tx: got %h expected d1d2d3", pack_tx()); end
        n_tests++; if (pack_acks() !== 64'h444) begin n_fail++; $display("FAIL b2b_acks: got %h expected 444", pack_acks()); end
    endtask

`ifndef ARB_TIMEOUT_EN
    task automatic test_hold();
        bit ok;
        clear_logs();
        rq[1].push_back(9'h061); drive();
        for (int i = 0; i < 50 && ack_log.size() == 0; i++) step();
        rq[3].push_back(9'h163); drive();
        repeat (200) step();
        n_tests++; if (grant !== 4'b0010 || busy !== 1'b1) begin n_fail++; $display("FAIL hold_grant: got grant=%b busy=%b expected 0010/1", grant, busy); end
        n_tests++; if (pack_acks() !== 64'h2) begin n_fail++; $display("FAIL hold_no_ack: got %h expected 2", pack_acks()); end
        rq[1].push_back(9'h162); drive();
        wait_idle(ok);
        n_tests++; if (!ok || pack_acks() !== 64'h224) begin n_fail++; $display("FAIL hold_acks: got %h expected 224", pack_acks()); end
        n_tests++; if (pack_tx() !== 64'h616263) begin n_fail++; $display("FAIL hold_tx: got %h expected 616263", pack_tx()); end
    endtask
`else
    task automatic test_timeout();
        bit ok;
        int t_done = -1, t_to = -1;
        logic prev_done = 1'b0;
        clear_logs();
        rq[1].push_back(9'h061); drive();
        for (int i = 0; i < 50 && ack_log.size() == 0; i++) step();
        rq[2].push_back(9'h172); drive();
        for (int i = 0; i < 400; i++) begin
            step();
            if (tx_done && !prev_done && t_done < 0) t_done = i;
            prev_done = tx_done;
            if (timeout) begin t_to = i; break; end
        end
        n_tests++; if (t_to < 0 || t_to - t_done != 17) begin n_fail++; $display("FAIL timeout_pulse: got delta %0d expected 17", t_to - t_done); end
        wait_idle(ok);
        n_tests++; if (!ok || pack_acks() !== 64'h23) begin n_fail++; $display("FAIL timeout_acks: got %h expected 23", pack_acks()); end
        n_tests++; if (pack_tx() !== 64'h6172) begin n_fail++; $display("FAIL timeout_tx: got %h expected 6172", pack_tx()); end
    endtask
`endif

    task automatic test_reset_mid();
        bit ok = 1'b0;
        logic prev_dv = 1'b0;
        int bad = 0;
        do_reset();
        clear_logs();
        rq[2].push_back(9'h071); rq[2].push_back(9'h072); rq[2].push_back(9'h173); drive();
        for (int i = 0; i < 500 && ack_log.size() < 2; i++) step();
        repeat (20) step();
        rst_n = 1'b0;
        #1;
        n_tests++; if (grant !== 4'b0000 || tx_dv !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL async_reset: got grant=%b dv=%b busy=%b expected 0000/0/0", grant, tx_dv, busy); end
        n_tests++; if (tx_active !== 1'b1) begin n_fail++; $display("FAIL reset_midbyte: got active=%b expected 1", tx_active); end
        for (int k = 0; k < N; k++) rq[k].delete();
        drive();
        step();
        rst_n = 1'b1;
        clear_logs();
        rq[3].push_back(9'h183); rq[1].push_back(9'h181); drive();
        for (int i = 0; i < 3000; i++) begin
            step();
            if (tx_dv && !prev_dv && tx_active) bad++;
            prev_dv = tx_dv;
            if (all_empty() && grant == '0 && m_state == M_IDLE && !tx_done) begin ok = 1'b1; break; end
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL reset_dv_wait: got %0d early DV expected 0", bad); end
        n_tests++; if (!ok || pack_acks() !== 64'h24) begin n_fail++; $display("FAIL reset_ptr_acks: got %h expected 24", pack_acks()); end
        n_tests++; if (pack_tx() !== 64'h8183) begin n_fail++; $display("FAIL reset_tx: got %h expected 8183", pack_tx()); end
    endtask

    initial begin
        rst_n = 1'b0; req = '0; req_byte = '0; req_last = '0;
        test_reset();
        test_single();
        test_pointer();
        do_reset();
        test_round_robin();
        test_packet();
        test_back_to_back();
`ifndef ARB_TIMEOUT_EN
        test_hold();
`else
        test_timeout();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
